// File: rtl/aud_recorder.sv
// Audio recorder: deserialises 16-bit ADC frames and writes them to SRAM at ascending addresses.
// Optional ring-buffer mode enabled by defining AUD_REC_RING_WRAP_EN.
module aud_recorder #(
  parameter logic [19:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  input  logic        i_lrc,
  input  logic        i_data,
  output logic [19:0] o_address,
  output logic [15:0] o_data,
  output logic        o_wr,
  output logic [19:0] o_record_counter,
  output logic        o_busy,
  output logic        o_finish
);

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StWrite} state_e;

`ifdef AUD_REC_RING_WRAP_EN
  localparam bit          RingWrap = 1'b1;
  localparam logic [19:0] CntMax   = (MAX_ADDR == 20'hFFFFF) ? 20'hFFFFF : MAX_ADDR + 20'd1;
`else
  localparam bit          RingWrap = 1'b0;
  localparam logic [19:0] CntMax   = 20'hFFFFF;
`endif

  state_e      state_q, state_d;
  logic        lrc_q, start_q;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [19:0] address_q, address_d;
  logic [15:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [19:0] cnt_q, cnt_d;
  logic        busy_q;
  logic        finish_q, finish_d;

  logic lrc_rise, start_rise;
  assign lrc_rise   = i_lrc & ~lrc_q;
  assign start_rise = i_start & ~start_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    address_d = address_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    cnt_d     = cnt_q;
    finish_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_rise && !i_stop) begin
          state_d = StWait;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (i_stop) begin
          state_d  = StIdle;
          finish_d = 1'b1;
        end else if (lrc_rise && !i_pause) begin
          state_d   = StCapture;
          bit_cnt_d = '0;
        end
      end
      StCapture: begin
        if (i_stop) begin
          state_d  = StIdle;
          finish_d = 1'b1;
        end else begin
          shift_d   = {shift_q[14:0], i_data};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Last bit: present the word now so o_wr is registered for the write cycle.
          if (bit_cnt_q == 4'd15) begin
            state_d   = StWrite;
            wr_d      = 1'b1;
            data_d    = {shift_q[14:0], i_data};
            address_d = addr_q;
          end
        end
      end
      StWrite: begin
        addr_d = (RingWrap && addr_q == MAX_ADDR) ? 20'd0 : addr_q + 20'd1;
        cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + 20'd1;
        if (i_stop || (!RingWrap && addr_q == MAX_ADDR)) begin
          state_d  = StIdle;
          finish_d = 1'b1;
        end else begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_q   <= StIdle;
      lrc_q     <= 1'b0;
      start_q   <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      address_q <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lrc_q     <= i_lrc;
      start_q   <= i_start;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      address_q <= address_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != StIdle);
      finish_q  <= finish_d;
    end
  end

  assign o_address        = address_q;
  assign o_data           = data_q;
  assign o_wr             = wr_q;
  assign o_record_counter = cnt_q;
  assign o_busy           = busy_q;
  assign o_finish         = finish_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder (MAX_ADDR = 3); expected writes are queued by the stimulus
// and checked by a negedge monitor for cycle, address and data.
module tb_aud_recorder;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_lrc = 1'b0;
  logic        i_data = 1'b0;
  logic [19:0] o_address;
  logic [15:0] o_data;
  logic        o_wr;
  logic [19:0] o_record_counter;
  logic        o_busy;
  logic        o_finish;

  aud_recorder #(.MAX_ADDR(20'd3)) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_pause         (i_pause),
    .i_stop          (i_stop),
    .i_lrc           (i_lrc),
    .i_data          (i_data),
    .o_address       (o_address),
    .o_data          (o_data),
    .o_wr            (o_wr),
    .o_record_counter(o_record_counter),
    .o_busy          (o_busy),
    .o_finish        (o_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [19:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   fin_cnt = 0;
  int   fin_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Write monitor and finish counter.
  always @(negedge clk) begin
    if (o_finish) fin_cnt++;
    if (o_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {12'd0, o_address}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {12'd0, o_address}, {12'd0, e.addr});
        chk("wr_data", {16'd0, o_data}, {16'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    tick();
  endtask

  // kind: 0 plain, 1 i_stop in period E+at, 2 reset in period E+at.
  task automatic frame(input logic [15:0] w, input bit exp_wr, input logic [19:0] addr,
                       input int kind, input int at);
    i_lrc = 1'b0;
    tick();
    tick();
    i_lrc = 1'b1;
    if (exp_wr) exp_q.push_back('{cyc: cyc + 17, addr: addr, data: w});
    tick();
    for (int off = 1; off <= 18; off++) begin
      i_data  = (off <= 16) ? w[16-off] : 1'b0;
      i_stop  = (kind == 1 && off == at);
      i_rst_n = (kind == 2 && off == at);
      tick();
      if (kind == 2 && off == at) begin
        chk("rst_wr", {31'd0, o_wr}, 32'd0);
        chk("rst_finish", {31'd0, o_finish}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_addr", {12'd0, o_address}, 32'd0);
        chk("rst_data", {16'd0, o_data}, 32'd0);
        chk("rst_cnt", {12'd0, o_record_counter}, 32'd0);
      end
    end
    i_stop  = 1'b0;
    i_rst_n = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    i_rst_n = 1'b0;
    tick();
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_wr", {31'd0, o_wr}, 32'd0);
    chk("reset_addr", {12'd0, o_address}, 32'd0);
    chk("reset_data", {16'd0, o_data}, 32'd0);
    chk("reset_cnt", {12'd0, o_record_counter}, 32'd0);

    // Single frame: latency, address 0, counter 1.
    start_pulse();
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    frame(16'hA5C3, 1'b1, 20'd0, 0, 0);
    chk("cnt_after_a5c3", {12'd0, o_record_counter}, 32'd1);
    stop_pulse();
    fin_exp++;
    chk("idle_after_stop", {31'd0, o_busy}, 32'd0);

    // Three consecutive frames.
    start_pulse();
    frame(16'h0001, 1'b1, 20'd0, 0, 0);
    frame(16'h8000, 1'b1, 20'd1, 0, 0);
    frame(16'h7FFF, 1'b1, 20'd2, 0, 0);
    chk("cnt_three", {12'd0, o_record_counter}, 32'd3);
    chk("hold_data", {16'd0, o_data}, 32'h7FFF);
    chk("hold_addr", {12'd0, o_address}, 32'd2);

    // Paused frames are skipped; next write lands on MAX_ADDR.
    i_pause = 1'b1;
    frame(16'h1111, 1'b0, 20'd0, 0, 0);
    frame(16'h2222, 1'b0, 20'd0, 0, 0);
    i_pause = 1'b0;
    frame(16'h1234, 1'b1, 20'd3, 0, 0);
    chk("cnt_at_max", {12'd0, o_record_counter}, 32'd4);
`ifdef AUD_REC_RING_WRAP_EN
    chk("busy_wrap", {31'd0, o_busy}, 32'd1);
    frame(16'h5555, 1'b1, 20'd0, 0, 0);
    chk("cnt_sat_wrap", {12'd0, o_record_counter}, 32'd4);
    stop_pulse();
`else
    chk("busy_end_max", {31'd0, o_busy}, 32'd0);
    chk("addr_hold_max", {12'd0, o_address}, 32'd3);
`endif
    fin_exp++;
    chk("finish_count_a", fin_cnt, fin_exp);

    // Stop during capture discards; stop during write keeps.
    start_pulse();
    frame(16'hBEEF, 1'b1, 20'd0, 0, 0);
    frame(16'hDEAD, 1'b0, 20'd0, 1, 8);
    fin_exp++;
    chk("cnt_after_cap_stop", {12'd0, o_record_counter}, 32'd1);
    chk("busy_after_cap_stop", {31'd0, o_busy}, 32'd0);
    chk("finish_count_b", fin_cnt, fin_exp);
    start_pulse();
    frame(16'h1111, 1'b1, 20'd0, 0, 0);
    frame(16'h0F0F, 1'b1, 20'd1, 1, 17);
    fin_exp++;
    chk("cnt_after_wr_stop", {12'd0, o_record_counter}, 32'd2);
    chk("busy_after_wr_stop", {31'd0, o_busy}, 32'd0);
    chk("finish_count_c", fin_cnt, fin_exp);

    // Start and stop together in idle: nothing happens.
    i_start = 1'b1;
    i_stop  = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop  = 1'b0;
    tick();
    tick();
    chk("start_stop_busy", {31'd0, o_busy}, 32'd0);
    chk("start_stop_finish", fin_cnt, fin_exp);

    // Reset mid-capture, then a fresh recording.
    start_pulse();
    frame(16'h0707, 1'b1, 20'd0, 0, 0);
    frame(16'h7070, 1'b1, 20'd1, 0, 0);
    frame(16'h3C3C, 1'b0, 20'd0, 2, 10);
    chk("finish_after_reset", fin_cnt, fin_exp);
    start_pulse();
    frame(16'hCAFE, 1'b1, 20'd0, 0, 0);
    chk("cnt_after_fresh", {12'd0, o_record_counter}, 32'd1);

    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 Parameter: MAX_ADDR, default 20'hFFFFF, highest SRAM word address written.
REQ-002 i_clk  in  1  bit clock (BCLK); all logic on rising edge; the only clock.
REQ-003 i_rst_n  in  1  reset; synchronous, active-high (asserted = 1) despite the suffix.
REQ-004 i_start  in  1  start request; acted on at its rising edge (registered compare).
REQ-005 i_pause  in  1  level; blocks new sample captures.
REQ-006 i_stop  in  1  level; aborts recording.
REQ-007 i_lrc  in  1  ADC LR clock.
REQ-008 i_data  in  1  ADC serial data, MSB first.
REQ-009 o_address  out  20  SRAM write address.
REQ-010 o_data  out  16  SRAM write data, two's complement sample.
REQ-011 o_wr  out  1  SRAM write strobe, one-cycle pulse.
REQ-012 o_record_counter  out  20  count of samples written; feeds the playback DSP record-length input.
REQ-013 o_busy  out  1  high in any state except S_IDLE.
REQ-014 o_finish  out  1  one-cycle pulse when a recording ends.

Function
REQ-015 States: S_IDLE, S_WAIT, S_CAPTURE, S_WRITE; all outputs registered.
REQ-016 S_IDLE: on an i_start rising edge with i_stop low -> S_WAIT; address = 0, counter = 0.
REQ-017 S_WAIT: an edge is a cycle E where i_lrc = 1 and the registered i_lrc = 0. On an edge with i_pause low -> S_CAPTURE, bit count = 0. When i_pause is high, edges are ignored.
REQ-018 S_CAPTURE: shift i_data in, MSB first, on cycles E+1..E+16. After the 16th bit -> S_WRITE.
REQ-019 S_WRITE (cycle E+17): o_wr = 1, o_data = captured word, o_address = current address. At the end of that cycle, address += 1 and counter += 1, then -> S_WAIT.
REQ-020 o_wr is low in every other cycle; o_data and o_address hold their last values between writes.
REQ-021 Latency from edge cycle E to the o_wr cycle is 17 cycles.
REQ-022 i_pause only affects S_WAIT; a capture already in progress completes and is written.
REQ-023 i_stop in S_WAIT or S_CAPTURE:
  - next state S_IDLE; the partial word is discarded (no o_wr);
  - o_finish pulses the next cycle;
  - o_record_counter and o_address hold.
REQ-024 i_stop in S_WRITE: the write completes (counter increments), then S_IDLE with an o_finish pulse.
REQ-025 i_stop and the i_start rising edge together in S_IDLE: stay in S_IDLE; no o_finish.
REQ-026 o_record_counter saturates at 20'hFFFFF.
REQ-027 A new i_start rising edge in S_IDLE restarts from address 0 and clears the counter.
REQ-028 i_start is ignored outside S_IDLE.

Reset
REQ-029 While i_rst_n = 1 at a clock edge, the block enters S_IDLE and clears every output, the shift register, the bit count and the registered i_lrc/i_start copies to 0.
REQ-030 Reset mid-capture or mid-write discards the word; o_wr is 0 the next cycle; no o_finish pulse.

Configuration
REQ-031 Macro AUD_REC_RING_WRAP_EN, defined:
  - the write to MAX_ADDR is followed by address 0 and recording continues (ring buffer);
  - o_record_counter saturates at min(MAX_ADDR+1, 20'hFFFFF);
  - only i_stop ends recording.
REQ-032 Macro AUD_REC_RING_WRAP_EN, undefined:
  - after the S_WRITE cycle at address MAX_ADDR, the next state is S_IDLE;
  - o_finish pulses once; o_address holds MAX_ADDR.

Verification
REQ-033 Start, then an edge with serial data 16'hA5C3 -> o_wr high exactly 17 cycles after edge E, o_data = 16'hA5C3, o_address = 0; then o_record_counter = 1.
REQ-034 Three consecutive frames with data 16'h0001, 16'h8000, 16'h7FFF -> writes at addresses 0, 1, 2 with those values; counter = 3.
REQ-035 i_pause high across two edges, then low -> no o_wr for the paused frames; the next write goes to the following address.
REQ-036 i_stop at bit 8 of a capture -> no o_wr; o_finish pulses once; counter unchanged. Then i_stop in an S_WRITE cycle -> that write is kept and the counter increments.
REQ-037 MAX_ADDR = 3, macro undefined -> four writes (addresses 0..3), then o_finish and S_IDLE. Macro defined -> the fifth write goes to address 0 and the counter holds at 4.
REQ-038 i_rst_n asserted at bit 10 of a capture -> all outputs 0 the next cycle; no o_wr or o_finish; a fresh start records from address 0.
